// File: rtl/deserialize4x2.sv
// deserialize4x2: gathers LANES narrow beats into one lane-packed word
// with valid/ready on both sides and an OR-reduction of the output lanes.
module deserialize4x2 #(
    parameter int WIDTH = 2,
    parameter int LANES = 4
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESETN,
    input  logic [WIDTH-1:0]         I,
    input  logic                     I_VALID,
    output logic                     I_READY,
    output logic [LANES*WIDTH-1:0]   O,
    output logic                     O_VALID,
    input  logic                     O_READY,
    output logic [WIDTH-1:0]         O_OR
);

    localparam int CW = $clog2(LANES);
    localparam logic [CW-1:0] LAST = CW'(LANES - 1);

    logic [CW-1:0]              cnt_q, cnt_d;
    logic [(LANES-1)*WIDTH-1:0] asm_q, asm_d;
    logic [LANES*WIDTH-1:0]     o_q, o_d;
    logic                       ov_q, ov_d;
    logic                       last;
    logic                       acc;
    logic                       take;
    logic [WIDTH-1:0]           or_red;

    assign last    = (cnt_q == LAST);
    assign I_READY = !last || !ov_q || O_READY;
    assign acc     = I_VALID && I_READY;
    assign take    = ov_q && O_READY;

    assign O       = o_q;
    assign O_VALID = ov_q;
    assign O_OR    = or_red;

    // Next state: fill lanes, then move the full word to the output register.
    always_comb begin
        cnt_d = cnt_q;
        asm_d = asm_q;
        o_d   = o_q;
        ov_d  = ov_q;
        if (acc && !last) begin
            cnt_d = cnt_q + 1'b1;
            for (int k = 0; k < LANES - 1; k++) begin
                if (cnt_q == CW'(k)) begin
                    asm_d[k*WIDTH +: WIDTH] = I;
                end
            end
        end
        if (acc && last) begin
            o_d   = {I, asm_q};
            ov_d  = 1'b1;
            cnt_d = '0;
        end else if (take) begin
            ov_d  = 1'b0;
        end
    end

    // OR of all lanes of the registered word.
    always_comb begin
        or_red = '0;
        for (int k = 0; k < LANES; k++) begin
            or_red = or_red | o_q[k*WIDTH +: WIDTH];
        end
    end

    // State registers; reset drops any partial word at once.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            cnt_q <= '0;
            asm_q <= '0;
            o_q   <= '0;
            ov_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
            o_q   <= o_d;
            ov_q  <= ov_d;
        end
    end

endmodule

// File: tb/tb_deserialize4x2.sv
// tb_deserialize4x2: scoreboard bench for deserialize4x2 with
// directed scenarios and a randomized handshake phase.
module tb_deserialize4x2;

    localparam int W = 2;
    localparam int L = 4;

    logic           CLK;
    logic           ASYNCRESETN;
    logic [W-1:0]   I;
    logic           I_VALID;
    logic           I_READY;
    logic [L*W-1:0] O;
    logic           O_VALID;
    logic           O_READY;
    logic [W-1:0]   O_OR;

    deserialize4x2 #(.WIDTH(W), .LANES(L)) dut (
        .CLK        (CLK),
        .ASYNCRESETN(ASYNCRESETN),
        .I          (I),
        .I_VALID    (I_VALID),
        .I_READY    (I_READY),
        .O          (O),
        .O_VALID    (O_VALID),
        .O_READY    (O_READY),
        .O_OR       (O_OR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int nvec = 0;
    int nerr = 0;

    logic [W-1:0]   part[$];
    logic [L*W-1:0] expq[$];
    logic [L*W-1:0] last_word = '0;
    bit             count_en = 0;
    int             ov_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] or_of(input logic [L*W-1:0] w);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < L; k++) begin
            r = r | W'((w >> (W * k)) & ((1 << W) - 1));
        end
        return r;
    endfunction

    // Reference model clears on the asynchronous reset.
    initial begin
        forever begin
            @(negedge ASYNCRESETN);
            part.delete();
            expq.delete();
            last_word = '0;
        end
    end

    // Model + monitor: predicts handshakes, checks outputs, tracks beats.
    initial begin
        logic           full;
        logic           er;
        logic [L*W-1:0] ew;
        logic [L*W-1:0] nw;
        forever begin
            @(negedge CLK);
            if (ASYNCRESETN) begin
                full = (expq.size() > 0);
                er = (part.size() != L - 1) || !full || O_READY;
                chk("i_ready", 32'(I_READY), 32'(er));
                chk("o_valid", 32'(O_VALID), 32'(full));
                ew = full ? expq[0] : last_word;
                chk("o_word", 32'(O), 32'(ew));
                chk("o_or", 32'(O_OR), 32'(or_of(ew)));
                if (count_en && O_VALID) ov_cnt++;
                if (full && O_READY) last_word = expq.pop_front();
                if (I_VALID && er) begin
                    part.push_back(I);
                    if (part.size() == L) begin
                        nw = '0;
                        for (int k = 0; k < L; k++) begin
                            nw = nw + ((L*W)'(part[k]) << (W * k));
                        end
                        expq.push_back(nw);
                        part.delete();
                    end
                end
            end
        end
    end

    task automatic send_beat(input logic [W-1:0] b, output int stalls);
        bit done;
        done = 0;
        stalls = 0;
        I_VALID = 1'b1;
        I = b;
        while (!done) begin
            @(negedge CLK);
            if (I_READY) done = 1;
            else stalls++;
            @(posedge CLK);
            #1;
            if (!done && stalls >= 50) begin
                nvec++;
                nerr++;
                $display("FAIL send_beat: beat %0h never accepted", b);
                done = 1;
            end
        end
        I_VALID = 1'b0;
        I = W'($urandom_range(0, 3));
    endtask

    initial begin
        int st;
        int tot;
        logic [W-1:0] gap_b [4];
        ASYNCRESETN = 1'b1;
        I_VALID = 1'b0;
        I = '0;
        O_READY = 1'b0;

        // reset between edges
        #2 ASYNCRESETN = 1'b0;
        #1;
        chk("rst_o", 32'(O), 32'h00);
        chk("rst_ov", 32'(O_VALID), 32'h0);
        chk("rst_or", 32'(O_OR), 32'h0);
        chk("rst_ir", 32'(I_READY), 32'h1);
        #3 ASYNCRESETN = 1'b1;
        @(posedge CLK);
        #1;

        // single word
        O_READY = 1'b1;
        send_beat(2'b01, st);
        send_beat(2'b10, st);
        send_beat(2'b11, st);
        send_beat(2'b00, st);
        chk("single_o", 32'(O), 32'h39);
        chk("single_ov", 32'(O_VALID), 32'h1);
        chk("single_or", 32'(O_OR), 32'h3);
        @(posedge CLK);
        #1;
        chk("single_ov2", 32'(O_VALID), 32'h0);
        chk("single_keep", 32'(O), 32'h39);

        // backpressure
        O_READY = 1'b0;
        tot = 0;
        send_beat(2'b01, st);
        send_beat(2'b10, st);
        send_beat(2'b11, st);
        send_beat(2'b00, st);
        send_beat(2'b11, st); tot += st;
        send_beat(2'b11, st); tot += st;
        send_beat(2'b11, st); tot += st;
        chk("bp_partial_stalls", 32'(tot), 32'h0);
        I_VALID = 1'b1;
        I = 2'b01;
        repeat (2) begin
            @(negedge CLK);
            chk("bp_stall_ir", 32'(I_READY), 32'h0);
            chk("bp_hold_o", 32'(O), 32'h39);
            @(posedge CLK);
            #1;
        end
        O_READY = 1'b1;
        @(negedge CLK);
        chk("bp_release_ir", 32'(I_READY), 32'h1);
        @(posedge CLK);
        #1;
        I_VALID = 1'b0;
        chk("bp_o", 32'(O), 32'h7F);
        chk("bp_ov", 32'(O_VALID), 32'h1);
        repeat (2) @(posedge CLK);
        #1;

        // streaming
        tot = 0;
        ov_cnt = 0;
        count_en = 1;
        for (int i = 0; i < 16; i++) begin
            send_beat(W'($urandom_range(0, 3)), st);
            tot += st;
        end
        @(negedge CLK);
        count_en = 0;
        @(posedge CLK);
        #1;
        chk("stream_words", 32'(ov_cnt), 32'd4);
        chk("stream_stalls", 32'(tot), 32'd0);

        // mid-word reset
        send_beat(2'b11, st);
        send_beat(2'b11, st);
        #1 ASYNCRESETN = 1'b0;
        #1;
        chk("mrst_o", 32'(O), 32'h00);
        chk("mrst_ov", 32'(O_VALID), 32'h0);
        chk("mrst_or", 32'(O_OR), 32'h0);
        chk("mrst_ir", 32'(I_READY), 32'h1);
        #1 ASYNCRESETN = 1'b1;
        @(posedge CLK);
        #1;
        send_beat(2'b01, st);
        send_beat(2'b00, st);
        send_beat(2'b00, st);
        send_beat(2'b00, st);
        chk("mrst_word", 32'(O), 32'h01);
        chk("mrst_wov", 32'(O_VALID), 32'h1);

        // gapped input with garbage on idle cycles
        gap_b[0] = 2'b10;
        gap_b[1] = 2'b01;
        gap_b[2] = 2'b10;
        gap_b[3] = 2'b01;
        for (int i = 0; i < 4; i++) begin
            send_beat(gap_b[i], st);
            if (i == 3) begin
                chk("gap_o", 32'(O), 32'h66);
                chk("gap_or", 32'(O_OR), 32'h3);
            end
            I = 2'b11;
            repeat (3) begin
                @(posedge CLK);
                #1;
            end
        end

        // randomized handshakes on both sides
        for (int i = 0; i < 400; i++) begin
            I_VALID = 1'($urandom_range(0, 1));
            I = W'($urandom_range(0, 3));
            O_READY = ($urandom_range(0, 3) != 0);
            @(posedge CLK);
            #1;
        end
        I_VALID = 1'b0;
        O_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("drain", 32'(expq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/deserialize4x2.md
# deserialize4x2

Sequential counterpart to the combinational lane-reduction blocks. It accepts a narrow stream of WIDTH-bit beats and assembles LANES consecutive beats into one LANES×WIDTH-bit word, in the same lane order the Or4x2-style blocks pack their inputs (lane 0 in the least-significant bits). A bitwise OR of the lanes is also provided so the output can be checked directly against the Or4 reduction. Both sides use a valid/ready handshake. The block sits between a narrow serial source and the lane-parallel logic on the board header.

## Interface
- WIDTH, default 2, bits per beat (lane width)
- LANES, default 4, beats per word (power of two, ≥2)

- CLK  in  1  clock, all state updates on rising edge
- ASYNCRESETN  in  1  asynchronous, active-low reset
- I  in  WIDTH  input beat
- I_VALID  in  1  beat on I is valid
- I_READY  out  1  block accepts beat this cycle
- O  out  LANES*WIDTH  assembled word; lane k occupies O[k*WIDTH +: WIDTH]
- O_VALID  out  1  O holds an unconsumed word
- O_READY  in  1  consumer takes O this cycle
- O_OR  out  WIDTH  bitwise OR of the LANES lanes of O (combinational from registered O)

## Operation
- State:
  - assembly register `asm` ((LANES-1)*WIDTH bits)
  - beat counter `cnt` (log2 LANES bits, 0..LANES-1)
  - output register `O`
  - flag `O_VALID`
- Input accept: `acc = I_VALID && I_READY`.
- Output take: `take = O_VALID && O_READY`.
- `I_READY = (cnt != LANES-1) || !O_VALID || O_READY`.
  - Partial beats are always accepted.
  - The completing beat stalls only while the output register is full and not draining.
- On `acc` with `cnt < LANES-1`:
  - `asm` lane `cnt` <= I
  - `cnt` <= `cnt`+1
- On `acc` with `cnt == LANES-1`:
  - `O` <= {I, asm}, so the last beat goes to the top lane
  - `O_VALID` <= 1
  - `cnt` <= 0
  - `asm` is left unchanged; it is overwritten lane by lane by the next word.
- No completing `acc` but `take`: `O_VALID` <= 0. `O` keeps its value (not cleared).
- Completing `acc` and `take` in the same cycle:
  - the new word replaces the old one
  - `O_VALID` stays 1
  - no bubble between words
- No `acc`: `cnt` and `asm` hold. Idle cycles between beats are allowed without limit.
- `O`/`O_VALID` are stable while `O_VALID && !O_READY`.
- I is ignored when `I_VALID` = 0.
- `O_OR` = `O[0 +: W] | O[W +: W] | …` across all lanes. It is 0 after reset.

## Timing
- Reset values: `cnt`=0, `asm`=0, `O`=0, `O_VALID`=0, `O_OR`=0.
  - `I_READY`=1 during and after reset, since `O_VALID`=0.
- Reset takes effect immediately, without waiting for CLK.
  - Deasserting it mid-word discards the partial word.
  - The first beat after reset lands in lane 0.
- Latency: the word appears on `O` with `O_VALID`=1 on the edge that accepts beat LANES-1. It is visible the following cycle.
- Throughput: one beat per cycle, so one word every LANES cycles under continuous `I_VALID` and `O_READY`.
- Combinational path: O_READY → I_READY only. There is no I → O combinational path.
- Backpressure: with `O_READY`=0 the block accepts LANES-1 further beats, then holds `I_READY`=0 with `cnt`=LANES-1 until `O_READY`=1.

## Test plan
- **Reset:**
  - Stimulus: assert ASYNCRESETN=0 between clock edges.
  - Required: O=8'h00, O_VALID=0, O_OR=2'b00, I_READY=1 immediately, with no clock edge needed.
- **Single word:**
  - Stimulus: with O_READY=1, send beats 2'b01, 2'b10, 2'b11, 2'b00 on consecutive cycles.
  - Required: the cycle after the 4th beat, O=8'h39, O_VALID=1, O_OR=2'b11. The next cycle, O_VALID=0 and O stays 8'h39.
- **Backpressure:**
  - Stimulus: hold O_READY=0, send word 8'h39, then beats 3, 3, 3, 1.
  - Required:
    - the first three beats are accepted
    - I_READY=0 on the 4th beat, and O stays 8'h39
  - Stimulus: raise O_READY.
  - Required: the 4th beat is accepted that cycle. Next cycle O=8'h7F, O_VALID=1 continuously.
- **Streaming:**
  - Stimulus: 16 back-to-back beats, O_READY=1.
  - Required:
    - exactly 4 words, O_VALID pulses every 4th cycle
    - I_READY never drops
    - lanes in arrival order
- **Mid-word reset:**
  - Stimulus: 2 beats (2'b11, 2'b11), then ASYNCRESETN pulse, then beats 1, 0, 0, 0.
  - Required: O=8'h01, not containing the stale 2'b11 lanes.
- **Gapped input:**
  - Stimulus: beats 2'b10, 2'b01, 2'b10, 2'b01 separated by 3 idle cycles each, with I_VALID=0 and I=2'b11 while idle.
  - Required: O=8'h66, O_OR=2'b11. The idle I values are ignored.
